// File: rtl/branch_resolve.sv
// branch_resolve -- execute-stage branch/jump resolution unit.
//
// Resolves a decoded conditional branch, JAL or JALR: evaluates the B-type
// condition (signed/unsigned XLEN-bit compare) and computes the architecturally
// correct next PC. It returns pc+4 as the link value to writeback. When the
// fetch prediction was wrong it issues a redirect. One-entry registered stage:
// results appear one cycle after accept and are held until each output channel
// handshakes on its own.
//
// Ports
//   clk, rst                        clock (rising edge), async active-high reset
//   in_valid / in_ready             input handshake
//   in_funct3, in_is_jal, in_is_jalr decoded branch kind
//   in_pc, in_rs1, in_rs2, in_imm    instruction PC, operands, sign-extended imm
//   in_pred_pc                      next PC that fetch already followed
//   flush                           kill held and incoming instruction
//   out_valid / out_ready           writeback channel handshake
//   out_taken, out_link, out_next_pc, out_illegal, out_misalign   writeback data
//   redirect_valid / redirect_ready fetch redirect handshake
//   redirect_pc                     restart address (same as out_next_pc)
module branch_resolve #(
   parameter int unsigned     XLEN   = 64,
   parameter logic [XLEN-1:0] RST_PC = '0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2:0]      in_funct3,
   input  logic            in_is_jal,
   input  logic            in_is_jalr,
   input  logic [XLEN-1:0] in_pc,
   input  logic [XLEN-1:0] in_rs1,
   input  logic [XLEN-1:0] in_rs2,
   input  logic [XLEN-1:0] in_imm,
   input  logic [XLEN-1:0] in_pred_pc,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic            out_taken,
   output logic [XLEN-1:0] out_link,
   output logic [XLEN-1:0] out_next_pc,
   output logic            out_illegal,
   output logic            out_misalign,
   output logic            redirect_valid,
   input  logic            redirect_ready,
   output logic [XLEN-1:0] redirect_pc
);

   typedef enum logic {IDLE, HOLD} state_t;

   state_t          state_q, state_d;
   logic            out_valid_q, out_valid_d;
   logic            redirect_valid_q, redirect_valid_d;
   logic            taken_q, taken_d;
   logic            illegal_q, illegal_d;
   logic            misalign_q, misalign_d;
   logic [XLEN-1:0] link_q, link_d;
   logic [XLEN-1:0] next_pc_q, next_pc_d;

   // Resolution of the offered instruction
   logic            is_jump;
   logic            eq, lt_s, lt_u, low_lt;
   logic            cond_taken, res_illegal, res_taken, res_misalign, res_mispredict;
   logic [XLEN-1:0] pc_plus4, jalr_sum, target, res_next_pc;

   // Channel / control
   logic            out_done, redirect_done, accept;

   always_comb begin
      is_jump = in_is_jal | in_is_jalr;
      eq      = (in_rs1 == in_rs2);
      low_lt  = (in_rs1[XLEN-2:0] < in_rs2[XLEN-2:0]);
      // Differing MSBs decide the compare on their own: a set rs1 MSB means
      // "less" for signed and "greater" for unsigned.
      lt_s    = (in_rs1[XLEN-1] != in_rs2[XLEN-1]) ? in_rs1[XLEN-1] : low_lt;
      lt_u    = (in_rs1[XLEN-1] != in_rs2[XLEN-1]) ? in_rs2[XLEN-1] : low_lt;

      cond_taken  = 1'b0;
      res_illegal = 1'b0;
      case (in_funct3)
         3'b000:  cond_taken = eq;
         3'b001:  cond_taken = ~eq;
         3'b100:  cond_taken = lt_s;
         3'b101:  cond_taken = ~lt_s;
         3'b110:  cond_taken = lt_u;
         3'b111:  cond_taken = ~lt_u;
         default: res_illegal = ~is_jump;
      endcase

      res_taken = is_jump | (cond_taken & ~res_illegal);

      pc_plus4 = in_pc + XLEN'(4);
      jalr_sum = in_rs1 + in_imm;
      target   = in_is_jalr ? {jalr_sum[XLEN-1:1], 1'b0} : (in_pc + in_imm);

      res_next_pc    = res_taken ? target : pc_plus4;
      res_misalign   = res_taken & target[1];
      res_mispredict = (res_next_pc != in_pred_pc) & ~res_misalign & ~res_illegal;
   end

   // A channel counts as done if it has nothing pending or handshakes now.
   always_comb begin
      out_done      = ~out_valid_q | out_ready;
      redirect_done = ~redirect_valid_q | redirect_ready;
      in_ready      = (state_q == IDLE) | (out_done & redirect_done);
      accept        = in_valid & in_ready & ~flush;
   end

   always_comb begin
      state_d          = state_q;
      out_valid_d      = out_valid_q & ~out_ready;
      redirect_valid_d = redirect_valid_q & ~redirect_ready;
      taken_d          = taken_q;
      illegal_d        = illegal_q;
      misalign_d       = misalign_q;
      link_d           = link_q;
      next_pc_d        = next_pc_q;

      if (flush) begin
         state_d          = IDLE;
         out_valid_d      = 1'b0;
         redirect_valid_d = 1'b0;
      end else if (accept) begin
         state_d          = HOLD;
         out_valid_d      = 1'b1;
         redirect_valid_d = res_mispredict;
         taken_d          = res_taken;
         illegal_d        = res_illegal;
         misalign_d       = res_misalign;
         link_d           = pc_plus4;
         next_pc_d        = res_next_pc;
      end else begin
         state_d = (out_valid_d | redirect_valid_d) ? HOLD : IDLE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q          <= IDLE;
         out_valid_q      <= 1'b0;
         redirect_valid_q <= 1'b0;
         taken_q          <= 1'b0;
         illegal_q        <= 1'b0;
         misalign_q       <= 1'b0;
         link_q           <= '0;
         next_pc_q        <= RST_PC;
      end else begin
         state_q          <= state_d;
         out_valid_q      <= out_valid_d;
         redirect_valid_q <= redirect_valid_d;
         taken_q          <= taken_d;
         illegal_q        <= illegal_d;
         misalign_q       <= misalign_d;
         link_q           <= link_d;
         next_pc_q        <= next_pc_d;
      end
   end

   always_comb begin
      out_valid      = out_valid_q;
      out_taken      = taken_q;
      out_link       = link_q;
      out_next_pc    = next_pc_q;
      out_illegal    = illegal_q;
      out_misalign   = misalign_q;
      redirect_valid = redirect_valid_q;
      redirect_pc    = next_pc_q;
   end

endmodule

// File: tb/tb_branch_resolve.sv
// tb_branch_resolve -- directed plus randomized checks of branch_resolve
// against a behavioural model of the branch/jump rules.
module tb_branch_resolve;

   localparam logic [63:0] RST_VAL = 64'h0000_0000_0000_0100;

   logic        clk, rst;
   logic        in_valid, in_ready;
   logic [2:0]  in_funct3;
   logic        in_is_jal, in_is_jalr;
   logic [63:0] in_pc, in_rs1, in_rs2, in_imm, in_pred_pc;
   logic        flush;
   logic        out_valid, out_ready, out_taken, out_illegal, out_misalign;
   logic [63:0] out_link, out_next_pc;
   logic        redirect_valid, redirect_ready;
   logic [63:0] redirect_pc;

   int unsigned vectors = 0;
   int unsigned errors  = 0;

   typedef struct packed {
      logic        taken;
      logic        illegal;
      logic        misalign;
      logic        redir;
      logic [63:0] link;
      logic [63:0] next_pc;
   } exp_t;

   branch_resolve #(.XLEN(64), .RST_PC(RST_VAL)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_funct3(in_funct3), .in_is_jal(in_is_jal), .in_is_jalr(in_is_jalr),
      .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
      .in_pred_pc(in_pred_pc), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .out_taken(out_taken),
      .out_link(out_link), .out_next_pc(out_next_pc), .out_illegal(out_illegal),
      .out_misalign(out_misalign),
      .redirect_valid(redirect_valid), .redirect_ready(redirect_ready),
      .redirect_pc(redirect_pc)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Behavioural reference: architectural branch rules with native arithmetic.
   function automatic exp_t model(input logic [2:0] f3, input logic jal, input logic jalr,
                                  input logic [63:0] pc, input logic [63:0] rs1,
                                  input logic [63:0] rs2, input logic [63:0] imm,
                                  input logic [63:0] pred);
      exp_t        e;
      logic [63:0] tgt;
      e.illegal = !jal && !jalr && (f3 == 3'd2 || f3 == 3'd3);
      if (jal || jalr) e.taken = 1'b1;
      else begin
         case (f3)
            3'd0:    e.taken = (rs1 == rs2);
            3'd1:    e.taken = (rs1 != rs2);
            3'd4:    e.taken = ($signed(rs1) <  $signed(rs2));
            3'd5:    e.taken = ($signed(rs1) >= $signed(rs2));
            3'd6:    e.taken = (rs1 <  rs2);
            3'd7:    e.taken = (rs1 >= rs2);
            default: e.taken = 1'b0;
         endcase
      end
      tgt        = jalr ? ((rs1 + imm) & ~64'd1) : (pc + imm);
      e.link     = pc + 64'd4;
      e.next_pc  = e.taken ? tgt : pc + 64'd4;
      e.misalign = e.taken && ((tgt % 64'd4) >= 64'd2);
      e.redir    = (e.next_pc != pred) && !e.misalign && !e.illegal;
      return e;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Presents one instruction (entered #1 after a rising edge), checks that it
   // is accepted, and checks the registered result one cycle later.
   task automatic do_txn(input string tag, input logic [2:0] f3, input logic jal,
                         input logic jalr, input logic [63:0] pc, input logic [63:0] rs1,
                         input logic [63:0] rs2, input logic [63:0] imm,
                         input logic [63:0] pred);
      exp_t e;
      in_funct3 = f3; in_is_jal = jal; in_is_jalr = jalr;
      in_pc = pc; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_pred_pc = pred;
      in_valid = 1'b1;
      e = model(f3, jal, jalr, pc, rs1, rs2, imm, pred);
      #1;
      chk({tag, ".in_ready"}, in_ready, 1'b1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk({tag, ".out_valid"}, out_valid, 1'b1);
      chk({tag, ".taken"}, out_taken, e.taken);
      chk({tag, ".next_pc"}, out_next_pc, e.next_pc);
      chk({tag, ".illegal"}, out_illegal, e.illegal);
      chk({tag, ".misalign"}, out_misalign, e.misalign);
      chk({tag, ".redirect_valid"}, redirect_valid, e.redir);
      if (e.redir) chk({tag, ".redirect_pc"}, redirect_pc, e.next_pc);
      if (jal || jalr) chk({tag, ".link"}, out_link, e.link);
   endtask

   task automatic idle_check(input string tag);
      @(posedge clk); #1;
      chk({tag, ".idle_out_valid"}, out_valid, 1'b0);
      chk({tag, ".idle_redirect_valid"}, redirect_valid, 1'b0);
      chk({tag, ".idle_in_ready"}, in_ready, 1'b1);
   endtask

   task automatic reset_check(input string tag);
      chk({tag, ".in_ready"}, in_ready, 1'b1);
      chk({tag, ".out_valid"}, out_valid, 1'b0);
      chk({tag, ".redirect_valid"}, redirect_valid, 1'b0);
      chk({tag, ".taken"}, out_taken, 1'b0);
      chk({tag, ".illegal"}, out_illegal, 1'b0);
      chk({tag, ".misalign"}, out_misalign, 1'b0);
      chk({tag, ".link"}, out_link, 64'd0);
      chk({tag, ".next_pc"}, out_next_pc, RST_VAL);
      chk({tag, ".redirect_pc"}, redirect_pc, RST_VAL);
   endtask

   initial begin
      logic [63:0] r1, r2, pc, imm, pred;
      logic [2:0]  f3;
      logic        jal, jalr;
      int unsigned sel;
      exp_t        e;

      rst = 1'b1; in_valid = 1'b0; flush = 1'b0;
      in_funct3 = '0; in_is_jal = 1'b0; in_is_jalr = 1'b0;
      in_pc = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0; in_pred_pc = '0;
      out_ready = 1'b1; redirect_ready = 1'b1;
      #1;
      reset_check("reset");
      @(posedge clk); #1;
      rst = 1'b0;

      // BLT with -1 < 1 taken, mispredicted
      do_txn("blt", 3'b100, 1'b0, 1'b0, 64'h1000, '1, 64'd1, 64'h20, 64'h1004);
      chk("blt.const_next_pc", out_next_pc, 64'h1020);
      chk("blt.const_redirect", redirect_valid, 1'b1);
      idle_check("blt");

      // BLTU with same operands: not taken, prediction correct
      do_txn("bltu", 3'b110, 1'b0, 1'b0, 64'h1000, '1, 64'd1, 64'h20, 64'h1004);
      chk("bltu.const_taken", out_taken, 1'b0);
      chk("bltu.const_redirect", redirect_valid, 1'b0);
      idle_check("bltu");

      // JALR aligned then misaligned target, back to back
      do_txn("jalr", 3'b000, 1'b0, 1'b1, 64'h3000, 64'h2001, 64'd0, 64'h4, 64'h2004);
      chk("jalr.const_next_pc", out_next_pc, 64'h2004);
      chk("jalr.const_link", out_link, 64'h3004);
      do_txn("jalr_mis", 3'b000, 1'b0, 1'b1, 64'h3000, 64'h2001, 64'd0, 64'h6, 64'h2004);
      chk("jalr_mis.const_misalign", out_misalign, 1'b1);
      chk("jalr_mis.const_redirect", redirect_valid, 1'b0);
      idle_check("jalr");

      // Illegal funct3, including PC wrap
      do_txn("ill", 3'b010, 1'b0, 1'b0, 64'h40, 64'd3, 64'd3, 64'h80, 64'h1234);
      chk("ill.const_next_pc", out_next_pc, 64'h44);
      do_txn("ill_wrap", 3'b010, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 64'd1, 64'd2, 64'h8, 64'h8);
      chk("ill_wrap.const_next_pc", out_next_pc, 64'd0);
      idle_check("ill");

      // Back-pressure on writeback; redirect completes on its own
      out_ready = 1'b0;
      do_txn("bp_jal", 3'b000, 1'b1, 1'b0, 64'h100, 64'd0, 64'd0, 64'h40, 64'h104);
      chk("bp.c1_redirect", redirect_valid, 1'b1);
      chk("bp.c1_in_ready", in_ready, 1'b0);
      @(posedge clk); #1;
      chk("bp.c2_out_valid", out_valid, 1'b1);
      chk("bp.c2_redirect", redirect_valid, 1'b0);
      chk("bp.c2_in_ready", in_ready, 1'b0);
      chk("bp.c2_next_pc", out_next_pc, 64'h140);
      @(posedge clk); #1;
      chk("bp.c3_out_valid", out_valid, 1'b1);
      chk("bp.c3_in_ready", in_ready, 1'b0);
      @(posedge clk); #1;
      chk("bp.c4_out_valid", out_valid, 1'b1);
      out_ready = 1'b1;
      do_txn("bp_beq", 3'b000, 1'b0, 1'b0, 64'h200, 64'd5, 64'd5, 64'h10, 64'h210);
      chk("bp_beq.const_next_pc", out_next_pc, 64'h210);
      idle_check("bp");

      // Flush in HOLD with both channels pending, new offer blocked
      out_ready = 1'b0; redirect_ready = 1'b0;
      do_txn("fl_jal", 3'b000, 1'b1, 1'b0, 64'h500, 64'd0, 64'd0, 64'h80, 64'h504);
      flush = 1'b1; in_valid = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      chk("flush.out_valid", out_valid, 1'b0);
      chk("flush.redirect_valid", redirect_valid, 1'b0);
      chk("flush.in_ready", in_ready, 1'b1);
      @(posedge clk); #1;
      chk("flush.blocked_accept", out_valid, 1'b0);

      // Asynchronous reset mid-HOLD
      do_txn("rst_jal", 3'b000, 1'b1, 1'b0, 64'h700, 64'd0, 64'd0, 64'h100, 64'h704);
      rst = 1'b1;
      #1;
      reset_check("rst_mid");
      @(posedge clk); #1;
      rst = 1'b0;
      out_ready = 1'b1; redirect_ready = 1'b1;

      // Randomized transactions, back to back with full readiness
      for (int i = 0; i < 300; i++) begin
         r1  = {$urandom, $urandom};
         sel = $urandom_range(0, 3);
         case (sel)
            0: r2 = r1;
            1: r2 = {$urandom, $urandom};
            2: r2 = r1 ^ 64'h8000_0000_0000_0000;
            default: r2 = r1 ^ 64'($urandom_range(1, 15));
         endcase
         pc  = {$urandom, $urandom} & ~64'd3;
         imm = 64'($signed(13'($urandom)));
         f3  = 3'($urandom);
         sel = $urandom_range(0, 5);
         jal  = (sel == 0);
         jalr = (sel == 1);
         e = model(f3, jal, jalr, pc, r1, r2, imm, 64'd0);
         pred = ($urandom_range(0, 1) == 0) ? e.next_pc : {$urandom, $urandom};
         do_txn("rand", f3, jal, jalr, pc, r1, r2, imm, pred);
         if ($urandom_range(0, 7) == 0) idle_check("rand");
      end
      idle_check("final");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
